// File: rtl/math_pipelined_op.sv
// Purpose: pipelined ADD/SUB/EQ/LTU; each stage works on one operand chunk and passes its carry, borrow or not-equal bit down the pipe.
// Latency: exactly LATENCY enabled cycles from an in_valid sample to out_valid; one transaction per enabled cycle.
// Backpressure: none; ce=0 freezes every stage and holds all outputs.
module math_pipelined_op #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  localparam int ALU_W  = (WIDTH + LATENCY - 1) / LATENCY;
  localparam int CHUNKS = (WIDTH + ALU_W - 1) / ALU_W;
  localparam int NOUT   = LATENCY - CHUNKS + 1;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_EQ  = 2'd2;
  localparam logic [1:0] OP_LTU = 2'd3;

  // Chunk stages. The chain bit means carry (ADD), borrow (SUB/LTU) or
  // "a differs from b so far" (EQ), so every chain starts from 0.
  for (genvar s = 0; s < CHUNKS; s++) begin : g_stage
    localparam int LO = s * ALU_W;
    localparam int CW = (LO + ALU_W > WIDTH) ? (WIDTH - LO) : ALU_W;

    logic             p_vld;
    logic [1:0]       p_op;
    logic [WIDTH-1:0] p_a;
    logic [WIDTH-1:0] p_b;
    logic [WIDTH-1:0] p_res;
    logic             p_chain;

    logic             q_vld;
    logic [1:0]       q_op;
    logic [WIDTH-1:0] q_a;
    logic [WIDTH-1:0] q_b;
    logic [WIDTH-1:0] q_res;
    logic             q_chain;

    logic [CW-1:0]    ca;
    logic [CW-1:0]    cb;
    logic [CW:0]      sum;
    logic [CW:0]      diff;
    logic [WIDTH-1:0] n_res;
    logic             n_chain;

    if (s == 0) begin : g_src
      assign p_vld   = in_valid;
      assign p_op    = op;
      assign p_a     = a;
      assign p_b     = b;
      assign p_res   = '0;
      assign p_chain = 1'b0;
    end else begin : g_src
      assign p_vld   = g_stage[s-1].q_vld;
      assign p_op    = g_stage[s-1].q_op;
      assign p_a     = g_stage[s-1].q_a;
      assign p_b     = g_stage[s-1].q_b;
      assign p_res   = g_stage[s-1].q_res;
      assign p_chain = g_stage[s-1].q_chain;
    end

    // Work on this stage's chunk only; earlier result chunks ride along untouched.
    always_comb begin
      ca      = p_a[LO +: CW];
      cb      = p_b[LO +: CW];
      sum     = {1'b0, ca} + {1'b0, cb} + {{CW{1'b0}}, p_chain};
      diff    = {1'b0, ca} - {1'b0, cb} - {{CW{1'b0}}, p_chain};
      n_res   = p_res;
      n_chain = 1'b0;
      case (p_op)
        OP_ADD: begin
          n_res[LO +: CW] = sum[CW-1:0];
          n_chain         = sum[CW];
        end
        OP_EQ: begin
          n_chain = p_chain | (ca != cb);
        end
        default: begin
          n_res[LO +: CW] = diff[CW-1:0];
          n_chain         = diff[CW];
        end
      endcase
    end

    // Stage register: one transaction, its skewed operands and partial result.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        q_vld   <= 1'b0;
        q_op    <= '0;
        q_a     <= '0;
        q_b     <= '0;
        q_res   <= '0;
        q_chain <= 1'b0;
      end else if (ce) begin
        q_vld   <= p_vld;
        q_op    <= p_op;
        q_a     <= p_a;
        q_b     <= p_b;
        q_res   <= n_res;
        q_chain <= n_chain;
      end
    end
  end

  logic             fin_vld;
  logic [1:0]       fin_op;
  logic [WIDTH-1:0] fin_full;
  logic             fin_chain;
  logic [WIDTH-1:0] fin_res;
  logic             fin_cy;
  logic             fin_zr;

  assign fin_vld   = g_stage[CHUNKS-1].p_vld;
  assign fin_op    = g_stage[CHUNKS-1].p_op;
  assign fin_full  = g_stage[CHUNKS-1].n_res;
  assign fin_chain = g_stage[CHUNKS-1].n_chain;

  // Shape the final result from the completed chain: compares collapse to one bit.
  always_comb begin
    fin_res = '0;
    fin_cy  = 1'b0;
    case (fin_op)
      OP_ADD, OP_SUB: begin
        fin_res = fin_full;
        fin_cy  = fin_chain;
      end
      OP_EQ: begin
        fin_res[0] = ~fin_chain;
      end
      OP_LTU: begin
        fin_res[0] = fin_chain;
        fin_cy     = fin_chain;
      end
      default: begin
        fin_res = '0;
      end
    endcase
    fin_zr = (fin_res == '0);
  end

  // Output stages: the first captures the finished result, the rest are
  // plain delay so the total latency is always LATENCY.
  for (genvar d = 0; d < NOUT; d++) begin : g_out
    logic             src_vld;
    logic [WIDTH-1:0] src_res;
    logic             src_cy;
    logic             src_zr;
    logic             q_vld;
    logic [WIDTH-1:0] q_res;
    logic             q_cy;
    logic             q_zr;

    if (d == 0) begin : g_src
      assign src_vld = fin_vld;
      assign src_res = fin_res;
      assign src_cy  = fin_cy;
      assign src_zr  = fin_zr;
    end else begin : g_src
      assign src_vld = g_out[d-1].q_vld;
      assign src_res = g_out[d-1].q_res;
      assign src_cy  = g_out[d-1].q_cy;
      assign src_zr  = g_out[d-1].q_zr;
    end

    // Delay register; reset leaves a zero result, so zero resets high.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        q_vld <= 1'b0;
        q_res <= '0;
        q_cy  <= 1'b0;
        q_zr  <= 1'b1;
      end else if (ce) begin
        q_vld <= src_vld;
        q_res <= src_res;
        q_cy  <= src_cy;
        q_zr  <= src_zr;
      end
    end
  end

  assign out_valid = g_out[NOUT-1].q_vld;
  assign result    = g_out[NOUT-1].q_res;
  assign carry     = g_out[NOUT-1].q_cy;
  assign zero      = g_out[NOUT-1].q_zr;

endmodule

// File: tb/tb_math_pipelined_op.sv
// Bench for math_pipelined_op: directed cases on 8/4, 10/3 and 8/1 builds,
// then a random stream with random stalls and bubbles checked against an arithmetic reference.
module tb_math_pipelined_op;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce;
  logic       in_valid;
  logic [1:0] op;
  logic [9:0] a10;
  logic [9:0] b10;
  logic [7:0] a8;
  logic [7:0] b8;

  assign a8 = a10[7:0];
  assign b8 = b10[7:0];

  logic       v_m, c_m, z_m;
  logic [7:0] r_m;
  logic       v_t, c_t, z_t;
  logic [9:0] r_t;
  logic       v_o, c_o, z_o;
  logic [7:0] r_o;

  int n_assert = 0;
  int n_fail   = 0;

  // Stream of transactions sampled at enabled edges since the last reset.
  bit         hv[$];
  logic [1:0] hop[$];
  logic [9:0] ha[$];
  logic [9:0] hb[$];

  math_pipelined_op #(.WIDTH(8), .LATENCY(4)) u_main (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .op(op), .a(a8), .b(b8),
    .out_valid(v_m), .result(r_m), .carry(c_m), .zero(z_m));

  math_pipelined_op #(.WIDTH(10), .LATENCY(3)) u_ten (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .op(op), .a(a10), .b(b10),
    .out_valid(v_t), .result(r_t), .carry(c_t), .zero(z_t));

  math_pipelined_op #(.WIDTH(8), .LATENCY(1)) u_one (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .op(op), .a(a8), .b(b8),
    .out_valid(v_o), .result(r_o), .carry(c_o), .zero(z_o));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] o, input logic [9:0] x, input logic [9:0] y);
    in_valid = v;
    op       = o;
    a10      = x;
    b10      = y;
  endtask

  // Check the 8-bit, latency-4 build; data fields only when a result is expected.
  task automatic chk_main(input string tag, input logic ev, input logic [7:0] er,
                          input logic ec, input logic ez);
    cmp({tag, ".vld"}, v_m, ev);
    if (ev) begin
      cmp({tag, ".res"}, r_m, er);
      cmp({tag, ".carry"}, c_m, ec);
      cmp({tag, ".zero"}, z_m, ez);
    end
  endtask

  // Reference: {zero, carry, result} straight from the arithmetic definitions.
  function automatic logic [65:0] ref_op(input int w, input logic [1:0] o,
                                         input logic [63:0] x, input logic [63:0] y);
    logic [63:0] mask;
    logic [63:0] xs, ys, full, res;
    logic        cy;
    mask = (64'd1 << w) - 64'd1;
    xs   = x & mask;
    ys   = y & mask;
    full = xs + ys;
    case (o)
      2'd0:    begin res = full & mask;      cy = full[w];   end
      2'd1:    begin res = (xs - ys) & mask; cy = (xs < ys); end
      2'd2:    begin res = {63'd0, xs == ys}; cy = 1'b0;     end
      default: begin res = {63'd0, xs < ys};  cy = (xs < ys); end
    endcase
    return {(res == 64'd0), cy, res};
  endfunction

  // Expected output of a build with latency lat: the transaction lat enabled edges back.
  task automatic chk_ref(input string tag, input int lat, input int w, input logic v,
                         input logic [63:0] r, input logic c, input logic z);
    int          idx;
    logic        ev;
    logic [65:0] e;
    idx = hv.size() - lat;
    ev  = (idx >= 0) ? hv[idx] : 1'b0;
    cmp({tag, ".vld"}, v, ev);
    if (ev) begin
      e = ref_op(w, hop[idx], {54'd0, ha[idx]}, {54'd0, hb[idx]});
      cmp({tag, ".res"}, r, e[63:0]);
      cmp({tag, ".carry"}, c, e[64]);
      cmp({tag, ".zero"}, z, e[65]);
    end
  endtask

  initial begin
    // Reset with a transaction presented: it must be ignored.
    rst_n = 1'b0;
    ce    = 1'b1;
    drive(1'b1, 2'd0, 10'h001, 10'h001);
    step();
    step();
    chk_main("reset", 1'b0, 8'h00, 1'b0, 1'b1);
    cmp("reset.res", r_m, 8'h00);
    cmp("reset.carry", c_m, 1'b0);
    cmp("reset.zero", z_m, 1'b1);
    cmp("reset.one_zero", z_o, 1'b1);
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 10'h000, 10'h000);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_main("ignored_in_reset", 1'b0, 8'h00, 1'b0, 1'b0);
    end

    // ADD 0xFF + 0x01 wraps to zero with carry.
    drive(1'b1, 2'd0, 10'h0FF, 10'h001);
    step();
    drive(1'b0, 2'd0, 10'h000, 10'h000);
    step();
    chk_main("add_wrap.e2", 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk_main("add_wrap.e3", 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk_main("add_wrap", 1'b1, 8'h00, 1'b1, 1'b1);
    step();
    chk_main("add_wrap.after", 1'b0, 8'h00, 1'b0, 1'b0);

    // Back-to-back SUB, EQ, LTU.
    drive(1'b1, 2'd1, 10'h010, 10'h020);
    step();
    drive(1'b1, 2'd2, 10'h05A, 10'h05A);
    step();
    drive(1'b1, 2'd3, 10'h003, 10'h002);
    step();
    drive(1'b0, 2'd0, 10'h000, 10'h000);
    step();
    chk_main("b2b.sub", 1'b1, 8'hF0, 1'b1, 1'b0);
    step();
    chk_main("b2b.eq", 1'b1, 8'h01, 1'b0, 1'b0);
    step();
    chk_main("b2b.ltu", 1'b1, 8'h00, 1'b0, 1'b1);
    step();
    chk_main("b2b.after", 1'b0, 8'h00, 1'b0, 1'b0);

    // Stall of three cycles after the second enabled edge.
    drive(1'b1, 2'd0, 10'h00F, 10'h001);
    step();
    drive(1'b0, 2'd0, 10'h000, 10'h000);
    step();
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_main("stall.hold", 1'b0, 8'h00, 1'b0, 1'b0);
    end
    ce = 1'b1;
    step();
    chk_main("stall.e3", 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk_main("stall.out", 1'b1, 8'h10, 1'b0, 1'b0);
    step();
    chk_main("stall.single", 1'b0, 8'h00, 1'b0, 1'b0);

    // Two transactions in flight, a third presented during a one-cycle reset.
    drive(1'b1, 2'd0, 10'h011, 10'h022);
    step();
    drive(1'b1, 2'd1, 10'h033, 10'h011);
    step();
    rst_n = 1'b0;
    drive(1'b1, 2'd0, 10'h044, 10'h001);
    step();
    chk_main("midreset", 1'b0, 8'h00, 1'b0, 1'b0);
    cmp("midreset.res", r_m, 8'h00);
    cmp("midreset.carry", c_m, 1'b0);
    cmp("midreset.zero", z_m, 1'b1);
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 10'h000, 10'h000);
    for (int i = 0; i < 6; i++) begin
      step();
      chk_main("midreset.flushed", 1'b0, 8'h00, 1'b0, 1'b0);
    end
    // First transaction after release keeps the normal latency.
    drive(1'b1, 2'd1, 10'h005, 10'h007);
    step();
    drive(1'b0, 2'd0, 10'h000, 10'h000);
    step();
    step();
    chk_main("postreset.e3", 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk_main("postreset", 1'b1, 8'hFE, 1'b1, 1'b0);

    // Odd split on the 10-bit, latency-3 build.
    drive(1'b1, 2'd0, 10'h3FF, 10'h001);
    step();
    drive(1'b0, 2'd0, 10'h000, 10'h000);
    step();
    cmp("odd.e2.vld", v_t, 1'b0);
    step();
    cmp("odd.vld", v_t, 1'b1);
    cmp("odd.res", r_t, 10'h000);
    cmp("odd.carry", c_t, 1'b1);
    cmp("odd.zero", z_t, 1'b1);
    step();
    cmp("odd.after.vld", v_t, 1'b0);

    // Random stream with bubbles and stalls, all three builds against the reference.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    hv.delete();
    hop.delete();
    ha.delete();
    hb.delete();
    for (int i = 0; i < 1400; i++) begin
      ce       = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 4) != 0);
      op       = 2'($urandom_range(0, 3));
      a10      = 10'($urandom);
      b10      = ($urandom_range(0, 3) == 0) ? a10 : 10'($urandom);
      if (ce) begin
        hv.push_back(in_valid);
        hop.push_back(op);
        ha.push_back(a10);
        hb.push_back(b10);
      end
      step();
      chk_ref("rnd.one", 1, 8, v_o, {56'd0, r_o}, c_o, z_o);
      chk_ref("rnd.main", 4, 8, v_m, {56'd0, r_m}, c_m, z_m);
      chk_ref("rnd.ten", 3, 10, v_t, {54'd0, r_t}, c_t, z_t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
